// File: rtl/hdmi_pattern_gen.sv
// Test-pattern pixel colourer: maps timing-generator coordinates to RGB in one of
// four frame-latched modes (gradient, colour bars, grid, solid) through a fixed 2-stage pipeline.
module hdmi_pattern_gen #(
  parameter int COORD_W   = 12,
  parameter int COLOUR_W  = 8,
  parameter int H_ACTIVE  = 1920,
  parameter int BAR_COUNT = 8,
  parameter int GRID_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COORD_W-1:0]    px_x,
  input  logic [COORD_W-1:0]    px_y,
  input  logic                  data_en,
  input  logic                  frame_start,
  input  logic [1:0]            mode_sel,
  input  logic [3*COLOUR_W-1:0] solid_rgb,
  output logic [COLOUR_W-1:0]   r,
  output logic [COLOUR_W-1:0]   g,
  output logic [COLOUR_W-1:0]   b,
  output logic                  data_en_out,
  output logic [1:0]            mode_active
);

  typedef enum logic [1:0] {
    MODE_GRADIENT = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_GRID     = 2'd2,
    MODE_SOLID    = 2'd3
  } mode_e;

  localparam int                 BAR_W        = H_ACTIVE / BAR_COUNT;
  localparam logic [COORD_W-1:0] BAR_PIX_LAST = COORD_W'(BAR_W - 1);
  localparam logic [2:0]         BAR_IDX_LAST = 3'(BAR_COUNT - 1);

  // Frame-level state
  mode_e                r_mode;
  logic [COLOUR_W-1:0]  r_frame_cnt;
  logic [2:0]           r_bar_idx;
  logic [COORD_W-1:0]   r_bar_pix;

  // Stage 1
  logic                  r_s1_en;
  mode_e                 r_s1_mode;
  logic [COLOUR_W-1:0]   r_s1_x;
  logic [COLOUR_W-1:0]   r_s1_y;
  logic                  r_s1_grid;
  logic [COLOUR_W-1:0]   r_s1_fcnt;
  logic [2:0]            r_s1_bar;
  logic [3*COLOUR_W-1:0] r_s1_solid;

  // Stage 2
  logic                  r_out_en;
  logic [3*COLOUR_W-1:0] r_out_rgb;

  mode_e                 w_mode_next;
  logic [COLOUR_W-1:0]   w_frame_cnt_next;
  logic [2:0]            w_bar_idx_cur;
  logic [COORD_W-1:0]    w_bar_pix_cur;
  logic                  w_grid_hit;
  logic [3*COLOUR_W-1:0] w_rgb;
  logic                  w_unused;

  // Only the low bits of px_y feed the colour logic.
  assign w_unused = ^px_y;

  assign w_grid_hit = (px_x[GRID_LOG2-1:0] == '0) || (px_y[GRID_LOG2-1:0] == '0);

  // The frame_start pixel already renders with the new mode and counter value.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_mode_next      = r_mode;
    w_frame_cnt_next = r_frame_cnt;
    if (frame_start) begin
      w_mode_next      = mode_e'(mode_sel);
      w_frame_cnt_next = r_frame_cnt + COLOUR_W'(1);
    end
  end

  // Bar position of the current pixel; px_x=0 restarts the line at bar 0.
  always_comb begin
    w_bar_idx_cur = r_bar_idx;
    w_bar_pix_cur = r_bar_pix + COORD_W'(1);
    if (px_x == '0) begin
      w_bar_idx_cur = '0;
      w_bar_pix_cur = '0;
    end else if (r_bar_pix == BAR_PIX_LAST) begin
      w_bar_pix_cur = '0;
      if (r_bar_idx != BAR_IDX_LAST) w_bar_idx_cur = r_bar_idx + 3'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode      <= MODE_GRADIENT;
      r_frame_cnt <= '0;
      r_bar_idx   <= '0;
      r_bar_pix   <= '0;
    end else begin
      r_mode      <= w_mode_next;
      r_frame_cnt <= w_frame_cnt_next;
      if (data_en) begin
        r_bar_idx <= w_bar_idx_cur;
        r_bar_pix <= w_bar_pix_cur;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_en    <= 1'b0;
      r_s1_mode  <= MODE_GRADIENT;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_grid  <= 1'b0;
      r_s1_fcnt  <= '0;
      r_s1_bar   <= '0;
      r_s1_solid <= '0;
    end else begin
      r_s1_en    <= data_en;
      r_s1_mode  <= w_mode_next;
      r_s1_x     <= px_x[COLOUR_W-1:0];
      r_s1_y     <= px_y[COLOUR_W-1:0];
      r_s1_grid  <= w_grid_hit;
      r_s1_fcnt  <= w_frame_cnt_next;
      r_s1_bar   <= w_bar_idx_cur;
      r_s1_solid <= solid_rgb;
    end
  end

  // Bar palette: red on {0,1,4,5}, green on {0..3}, blue on even indices.
  always_comb begin
    w_rgb = '0;
    unique case (r_s1_mode)
      MODE_GRADIENT: w_rgb = {r_s1_x, r_s1_y, r_s1_fcnt};
      MODE_BARS:     w_rgb = {{COLOUR_W{~r_s1_bar[1]}},
                              {COLOUR_W{~r_s1_bar[2]}},
                              {COLOUR_W{~r_s1_bar[0]}}};
      MODE_GRID:     w_rgb = {(3*COLOUR_W){r_s1_grid}};
      MODE_SOLID:    w_rgb = r_s1_solid;
      default:       w_rgb = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_en  <= 1'b0;
      r_out_rgb <= '0;
    end else begin
      r_out_en  <= r_s1_en;
      r_out_rgb <= r_s1_en ? w_rgb : '0;
    end
  end

  assign r           = r_out_rgb[3*COLOUR_W-1:2*COLOUR_W];
  assign g           = r_out_rgb[2*COLOUR_W-1:COLOUR_W];
  assign b           = r_out_rgb[COLOUR_W-1:0];
  assign data_en_out = r_out_en;
  assign mode_active = r_mode;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Scoreboard bench for hdmi_pattern_gen: a driver pushes model predictions,
// a monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_hdmi_pattern_gen;

  localparam int XW    = 12;
  localparam int CW    = 8;
  localparam int H     = 1920;
  localparam int BARS  = 8;
  localparam int BAR_W = H / BARS;
  localparam int GRID  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [XW-1:0] px_x, px_y;
  logic          data_en, frame_start;
  logic [1:0]    mode_sel;
  logic [23:0]   solid_rgb;
  logic [CW-1:0] r, g, b;
  logic          data_en_out;
  logic [1:0]    mode_active;

  hdmi_pattern_gen #(
    .COORD_W(XW), .COLOUR_W(CW), .H_ACTIVE(H), .BAR_COUNT(BARS), .GRID_LOG2(6)
  ) dut (
    .clk(clk), .rst(rst), .px_x(px_x), .px_y(px_y), .data_en(data_en),
    .frame_start(frame_start), .mode_sel(mode_sel), .solid_rgb(solid_rgb),
    .r(r), .g(g), .b(b), .data_en_out(data_en_out), .mode_active(mode_active)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [24:0] val; string tag; } pix_exp_t;
  typedef struct { int due; logic [1:0] mode; } mode_exp_t;

  pix_exp_t  pix_q[$];
  mode_exp_t mode_q[$];

  int cyc    = 0;
  int n_vec  = 0;
  int n_err  = 0;

  // Reference model state
  int m_mode = 0;
  int m_fcnt = 0;
  int m_run  = 0;   // active pixels since the last px_x=0 pixel

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [23:0] ref_pixel(input int x, input int y, input logic [23:0] solid);
    int idx;
    case (m_mode)
      0: return {8'(x % 256), 8'(y % 256), 8'(m_fcnt)};
      1: begin
        idx = m_run / BAR_W;
        if (idx > BARS - 1) idx = BARS - 1;
        return bar_tab[idx];
      end
      2: return ((x % GRID == 0) || (y % GRID == 0)) ? 24'hFFFFFF : 24'h000000;
      default: return solid;
    endcase
  endfunction

  task automatic drive(input string tag, input int x, input int y, input bit en,
                       input bit fs, input int msel, input logic [23:0] solid);
    pix_exp_t  pe;
    mode_exp_t me;
    @(negedge clk);
    px_x        = XW'(x);
    px_y        = XW'(y);
    data_en     = en;
    frame_start = fs;
    mode_sel    = 2'(msel);
    solid_rgb   = solid;
    if (fs) begin
      m_mode = msel;
      m_fcnt = (m_fcnt + 1) % 256;
    end
    if (en) m_run = (x == 0) ? 0 : m_run + 1;
    pe.due = cyc + 2;
    pe.val = en ? {1'b1, ref_pixel(x, y, solid)} : 25'd0;
    pe.tag = tag;
    pix_q.push_back(pe);
    me.due  = cyc + 1;
    me.mode = 2'(m_mode);
    mode_q.push_back(me);
  endtask

  task automatic release_reset();
    @(negedge clk);
    data_en     = 1'b0;
    frame_start = 1'b0;
    rst         = 1'b0;
  endtask

  // Monitor: compares each expectation on the cycle it falls due
  initial begin
    pix_exp_t  pe;
    mode_exp_t me;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mode_q.size() != 0 && mode_q[0].due == cyc) begin
        me = mode_q.pop_front();
        check("mode_active", 32'(mode_active), 32'(me.mode));
      end
      if (pix_q.size() != 0 && pix_q[0].due == cyc) begin
        pe = pix_q.pop_front();
        check(pe.tag, {7'd0, data_en_out, r, g, b}, {7'd0, pe.val});
      end
    end
  end

  initial begin
    rst = 1'b1; px_x = '0; px_y = '0; data_en = 1'b0; frame_start = 1'b0;
    mode_sel = '0; solid_rgb = '0;
    repeat (3) @(negedge clk);
    release_reset();

    // Reset mid-stream: run bars, then assert reset asynchronously
    drive("pre_rst", 0, 0, 1, 1, 1, 24'h0);
    for (int x = 1; x < 6; x++) drive("pre_rst", x, 0, 1, 0, 1, 24'h0);
    #2 rst = 1'b1;
    #1;
    check("rst_r", 32'(r), 0);
    check("rst_g", 32'(g), 0);
    check("rst_b", 32'(b), 0);
    check("rst_den", 32'(data_en_out), 0);
    check("rst_mode", 32'(mode_active), 0);
    pix_q.delete();
    mode_q.delete();
    m_mode = 0; m_fcnt = 0; m_run = 0;
    repeat (2) @(negedge clk);
    release_reset();
    drive("post_rst", 5, 7, 1, 0, 0, 24'h0);

    // Gradient and frame counter wrap
    for (int i = 0; i < 3; i++) drive("grad_fs", 0, 0, 1, 1, 0, 24'h0);
    drive("grad_300_260", 300, 260, 1, 0, 0, 24'h0);
    for (int i = 0; i < 256; i++) drive("grad_blank_fs", 0, 0, 0, 1, 0, 24'h0);
    drive("grad_wrap", 300, 260, 1, 0, 0, 24'h0);

    // Colour bars over a full line, with a data_en gap mid-line
    drive("bars", 0, 0, 1, 1, 1, 24'h0);
    for (int x = 1; x < H; x++) begin
      if (x == 1000) for (int k = 0; k < 10; k++) drive("bars_gap", x, 0, 0, 0, 1, 24'h0);
      drive("bars", x, 0, 1, 0, 1, 24'h0);
    end
    for (int x = 0; x < 8; x++) drive("bars_line2", x, 1, 1, 0, 1, 24'h0);

    // Grid
    drive("grid_00", 0, 0, 1, 1, 2, 24'h0);
    drive("grid_64_5", 64, 5, 1, 0, 2, 24'h0);
    drive("grid_65_5", 65, 5, 1, 0, 2, 24'h0);
    drive("grid_65_128", 65, 128, 1, 0, 2, 24'h0);

    // Mode latch: mid-frame change has no effect until frame_start
    drive("latch_fs", 0, 0, 1, 1, 0, 24'h102030);
    drive("latch_pre", 10, 1, 1, 0, 0, 24'h102030);
    drive("latch_mid", 11, 1, 1, 0, 3, 24'h102030);
    drive("latch_mid", 12, 1, 1, 0, 3, 24'h102030);
    drive("latch_new", 0, 0, 1, 1, 3, 24'h102030);
    drive("latch_new", 1, 0, 1, 0, 3, 24'h102030);

    // Blanking and latency
    drive("blank_1", 2, 0, 1, 0, 3, 24'h102030);
    drive("blank_0", 3, 0, 0, 0, 3, 24'h102030);
    drive("blank_1b", 3, 0, 1, 0, 3, 24'h102030);

    // Randomised traffic
    begin
      int x, y, ms;
      bit en, fs;
      x = 0; y = 0;
      for (int i = 0; i < 3000; i++) begin
        x  = ($urandom_range(0, 15) == 0) ? 0 : (x + 1) % H;
        y  = $urandom_range(0, 1079);
        en = ($urandom_range(0, 4) != 0);
        fs = ($urandom_range(0, 39) == 0);
        ms = $urandom_range(0, 3);
        drive("random", x, y, en, fs, ms, 24'($urandom));
      end
    end

    // Drain and confirm every expectation was consumed
    for (int i = 0; i < 3; i++) drive("drain", 0, 0, 0, 0, 0, 24'h0);
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(pix_q.size() + mode_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
